block_io_sequencer: RTL and testbench
=====================================

Name: block_io_sequencer

Overview:
- Parametrised sequencer for the Z80 block I/O family: INI/INIR/IND/INDR and OUTI/OTIR/OUTD/OTDR.
- Replaces per-opcode T-state decode with one FSM that runs its own mem/IO handshakes, updates HL and B, and produces the Z/N flag results.
- Supports repeat with interrupt rewind.
- Sits beside the execute unit. The execute unit loads HL/B/C, pulses start, and consumes the results on done.

Parameters:
DATA_W, 8, width of data bus and of B and C; IO address is {B,C} (2*DATA_W bits)
ADDR_W, 16, memory address width (HL)

Ports:
clock  in  1  system clock, rising edge
notReset  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
op_in  in  1  1 = IN family (IO->mem), 0 = OUT family (mem->IO)
op_dec  in  1  1 = HL decrements (IND/OUTD), 0 = increments
op_rep  in  1  1 = repeat form (xxIR/xxDR)
hl_in  in  ADDR_W  HL value at start
b_in  in  DATA_W  B value at start
c_in  in  DATA_W  C value at start
irq_pending  in  1  interrupt pending, sampled at end of each iteration
mem_req/mem_we  out  1/1  memory request / write strobe
mem_addr  out  ADDR_W  memory address (= HL)
mem_wdata  out  DATA_W  memory write data
mem_rdata/mem_ack  in  DATA_W/1  memory read data / acknowledge
io_req/io_we  out  1/1  IO request / write strobe
io_addr  out  2*DATA_W  IO port address
io_wdata  out  DATA_W  IO write data
io_rdata/io_ack  in  DATA_W/1  IO read data / acknowledge
hl_out/b_out  out  ADDR_W/DATA_W  working HL/B, valid whenever done=1
flag_z/flag_n/flag_we  out  1/1/1  Z result, N result, one-cycle flag write strobe
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse: instruction complete
rewind  out  1  one-cycle pulse, alongside done: repeat interrupted, PC must be rewound by 2
xpt  out  5  iteration T-state counter (see Optional Feature)

Behaviour:
- Reset (async, notReset=0):
  - state=IDLE.
  - All req/we/done/rewind/flag_we/busy=0.
  - hl_out, b_out, flag_z, flag_n, data latch, xpt = 0.
  - Requests drop immediately, including when reset hits mid-operation.
- States: IDLE, SRC, DST, UPD.
- IDLE:
  - start=1: latch hl_in/b_in/c_in/op bits, then go to SRC.
  - start while busy is ignored.
- SRC (source access):
  - IN: io_req=1, io_we=0, io_addr={B,C}.
  - OUT: mem_req=1, mem_we=0, mem_addr=HL.
  - Request stays asserted and stable until ack=1 at a rising edge. On that edge: latch rdata, go to DST. Request drops in the next state.
- DST (destination access):
  - IN: mem_req=1, mem_we=1, mem_addr=HL, mem_wdata=latch.
  - OUT: io_req=1, io_we=1, io_addr={B-1 mod 2^DATA_W, C}, io_wdata=latch.
  - The OUT family uses the predecremented B as the port address.
  - Ack edge: go to UPD.
- UPD (one cycle, flag_we=1):
  - HL += 1, or -= 1 when op_dec; wraps modulo 2^ADDR_W.
  - B -= 1, wraps (B=0 at start gives 2^DATA_W iterations in repeat mode).
  - flag_z = (new B == 0); flag_n = latch[DATA_W-1].
  - Next state:
    - op_rep=1, new B != 0 and irq_pending=0: back to SRC (no done).
    - op_rep=1, new B != 0 and irq_pending=1: IDLE with done=1 and rewind=1.
    - Otherwise: IDLE with done=1, rewind=0.
- done/rewind are registered: high during the first IDLE cycle after UPD.
- Zero-wait acks give 3 cycles per iteration: SRC, DST, UPD.
- Each wait cycle (ack=0) extends the current state by 1 cycle.
- An ack with no outstanding request is ignored.

Optional Feature:
- Macro BLOCK_IO_SEQUENCER_XPT_EN.
- Defined:
  - xpt counts clock cycles within the current iteration: 0 in the first SRC cycle, +1 each cycle, saturates at 31.
  - Resets to 0 on every re-entry to SRC and in IDLE.
  - Used for timing-trace comparison against the legacy T-state decoders.
- Undefined: xpt is tied to 0 and the counter is not built.

Test Plan:
- OUTI, HL=0x4000, B=0x03, C=0x10, mem_rdata=0x85, zero-wait:
  - mem read at 0x4000.
  - io write at addr 0x0210, data 0x85.
  - Result: hl_out=0x4001, b_out=0x02, flag_z=0, flag_n=1, done at cycle 4 after start.
- INDR, HL=0x8000, B=0x02, C=0x20, io_rdata 0x11 then 0x22:
  - IO reads at 0x0220 then 0x0120.
  - Mem writes 0x11@0x8000, 0x22@0x7FFF.
  - Result: hl_out=0x7FFE, b_out=0, flag_z=1, a single done, rewind=0.
- OTIR, B=0x05, irq_pending raised during iteration 2:
  - Iteration 2 UPD leaves b_out=0x03.
  - done=1 and rewind=1 in the same cycle; no third access.
- INI with mem_ack delayed 3 cycles:
  - mem_req/mem_addr/mem_wdata stable for 4 cycles.
  - Iteration takes 6 cycles.
  - With XPT_EN: xpt reaches 5 in UPD.
- OTDR, B=0x00 at start:
  - Runs 256 iterations; first io_addr high byte 0xFF.
  - HL decrements by 256; final flag_z=1.
- notReset pulled low during DST of INIR:
  - mem_req drops immediately and busy=0.
  - After release, a start=1 pulse begins a fresh instruction correctly.

Source files
------------

// File: rtl/block_io_sequencer.sv
// -----------------------------------------------------------------------------
// block_io_sequencer
//
// Sequencer for the Z80 block I/O group (INI/INIR/IND/INDR, OUTI/OTIR/OUTD/OTDR).
// One iteration is SRC (read) -> DST (write) -> UPD (HL/B bookkeeping, flags).
// Repeat forms loop back to SRC until B reaches zero or an interrupt is
// pending, in which case the instruction ends with rewind so the execute
// unit can back PC up over the opcode.
//
// Optional feature macro: BLOCK_IO_SEQUENCER_XPT_EN
//   defined   : xpt counts cycles within the current iteration (saturating)
//   undefined : xpt is tied to 0
//
// Ports
//   clock, notReset           clock (rising edge), async active-low reset
//   start, op_in/op_dec/op_rep instruction request and opcode bits
//   hl_in, b_in, c_in         register values captured on start
//   irq_pending               interrupt pending, sampled in UPD
//   mem_*                     memory handshake (req held until ack)
//   io_*                      IO handshake (req held until ack), port {B,C}
//   hl_out, b_out             working HL/B
//   flag_z, flag_n, flag_we   Z/N results and write strobe (high in UPD)
//   busy, done, rewind        status; done/rewind are one-cycle pulses
//   xpt                       per-iteration cycle counter
// -----------------------------------------------------------------------------
module block_io_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  start,
    input  logic                  op_in,
    input  logic                  op_dec,
    input  logic                  op_rep,
    input  logic [ADDR_W-1:0]     hl_in,
    input  logic [DATA_W-1:0]     b_in,
    input  logic [DATA_W-1:0]     c_in,
    input  logic                  irq_pending,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  io_req,
    output logic                  io_we,
    output logic [2*DATA_W-1:0]   io_addr,
    output logic [DATA_W-1:0]     io_wdata,
    input  logic [DATA_W-1:0]     io_rdata,
    input  logic                  io_ack,
    output logic [ADDR_W-1:0]     hl_out,
    output logic [DATA_W-1:0]     b_out,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_we,
    output logic                  busy,
    output logic                  done,
    output logic                  rewind,
    output logic [4:0]            xpt
);

    typedef enum logic [1:0] {IDLE, SRC, DST, UPD} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   hl_q;
    logic [DATA_W-1:0]   b_q, c_q, data_q;
    logic                op_in_q, op_dec_q, op_rep_q;
    logic                flag_z_q, flag_n_q, done_q, rewind_q;

    logic                src_ack, dst_ack, rep_go;
    logic [DATA_W-1:0]   src_rdata, b_dec;
    logic [ADDR_W-1:0]   hl_step;

    // IN family reads IO and writes memory; OUT family the other way round.
    // Only the ack of the channel currently requested is looked at, so a
    // stray ack on the idle channel has no effect.
    assign src_ack   = op_in_q ? io_ack   : mem_ack;
    assign dst_ack   = op_in_q ? mem_ack  : io_ack;
    assign src_rdata = op_in_q ? io_rdata : mem_rdata;

    assign b_dec   = b_q - DATA_W'(1);
    assign hl_step = op_dec_q ? (hl_q - ADDR_W'(1)) : (hl_q + ADDR_W'(1));

    // HL/B are already updated when UPD is entered, so b_q here is the new B.
    assign rep_go = op_rep_q && (b_q != '0);

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)   state_d = SRC;
            SRC:  if (src_ack) state_d = DST;
            DST:  if (dst_ack) state_d = UPD;
            UPD:  state_d = (rep_go && !irq_pending) ? SRC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            hl_q     <= '0;
            b_q      <= '0;
            c_q      <= '0;
            data_q   <= '0;
            op_in_q  <= 1'b0;
            op_dec_q <= 1'b0;
            op_rep_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            done_q   <= 1'b0;
            rewind_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                hl_q     <= hl_in;
                b_q      <= b_in;
                c_q      <= c_in;
                op_in_q  <= op_in;
                op_dec_q <= op_dec;
                op_rep_q <= op_rep;
            end
            if (state_q == SRC && src_ack) data_q <= src_rdata;
            // Commit HL/B/flags on the destination ack so they are already
            // valid while flag_we is high in UPD.
            if (state_q == DST && dst_ack) begin
                hl_q     <= hl_step;
                b_q      <= b_dec;
                flag_z_q <= (b_dec == '0);
                flag_n_q <= data_q[DATA_W-1];
            end
            done_q   <= (state_q == UPD) && (state_d == IDLE);
            rewind_q <= (state_q == UPD) && rep_go && irq_pending;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        io_req    = 1'b0;
        io_we     = 1'b0;
        mem_addr  = hl_q;
        mem_wdata = data_q;
        io_wdata  = data_q;
        // OUT writes use the predecremented B as the port high byte.
        io_addr   = {(state_q == DST) ? b_dec : b_q, c_q};
        case (state_q)
            SRC: begin
                io_req  = op_in_q;
                mem_req = !op_in_q;
            end
            DST: begin
                mem_req = op_in_q;
                mem_we  = op_in_q;
                io_req  = !op_in_q;
                io_we   = !op_in_q;
            end
            default: ;
        endcase
        busy    = (state_q != IDLE);
        flag_we = (state_q == UPD);
    end

    assign hl_out = hl_q;
    assign b_out  = b_q;
    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
    assign done   = done_q;
    assign rewind = rewind_q;

`ifdef BLOCK_IO_SEQUENCER_XPT_EN
    logic [4:0] xpt_q, xpt_d;

    // Zero on every entry into SRC and while idle; otherwise count up and
    // hold at 31.
    always_comb begin
        xpt_d = xpt_q;
        if (state_d == IDLE || (state_d == SRC && state_q != SRC)) xpt_d = '0;
        else if (xpt_q != 5'd31)                                   xpt_d = xpt_q + 5'd1;
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) xpt_q <= '0;
        else           xpt_q <= xpt_d;
    end

    assign xpt = xpt_q;
`else
    assign xpt = '0;
`endif

endmodule

// File: tb/tb_block_io_sequencer.sv
module tb_block_io_sequencer;

    logic        clock = 1'b0;
    logic        notReset, start, op_in, op_dec, op_rep, irq_pending;
    logic [15:0] hl_in;
    logic [7:0]  b_in, c_in;
    logic        mem_req, mem_we, mem_ack, io_req, io_we, io_ack;
    logic [15:0] mem_addr, io_addr, hl_out;
    logic [7:0]  mem_wdata, mem_rdata, io_wdata, io_rdata, b_out;
    logic        flag_z, flag_n, flag_we, busy, done, rewind;
    logic [4:0]  xpt;

    always #5 clock = ~clock;

    block_io_sequencer #(.DATA_W(8), .ADDR_W(16)) dut (
        .clock(clock), .notReset(notReset), .start(start),
        .op_in(op_in), .op_dec(op_dec), .op_rep(op_rep),
        .hl_in(hl_in), .b_in(b_in), .c_in(c_in), .irq_pending(irq_pending),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack),
        .hl_out(hl_out), .b_out(b_out), .flag_z(flag_z), .flag_n(flag_n),
        .flag_we(flag_we), .busy(busy), .done(done), .rewind(rewind), .xpt(xpt)
    );

    typedef struct {
        string       name;
        logic        op_in, op_dec, op_rep;
        logic [15:0] hl;
        logic [7:0]  b, c, d0, step;
        int          irq_at, mw, iw;
        logic [15:0] e_hl;
        logic [7:0]  e_b;
        logic        e_z, e_n, e_rw;
        int          e_iters, e_cyc, e_xpt;
    } vec_t;

    typedef struct {
        logic        is_io;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    acc_t sb[$];
    vec_t vecs[7];

    int checks = 0, errors = 0;
    int mem_wait = 0, io_wait = 0, irq_at = 0, rd_cnt = 0, upd_cnt = 0, stab_err = 0;
    logic [7:0] cur_d0 = 8'h00, cur_step = 8'h00;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Scoreboard: compare an observed access against the oldest expected one.
    function automatic void log_access(logic is_io, logic we, logic [15:0] addr, logic [7:0] data);
        acc_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got io=%0d we=%0d addr=%h data=%h, expected none",
                     is_io, we, addr, data);
        end else begin
            e = sb.pop_front();
            if (e.is_io !== is_io || e.we !== we || e.addr !== addr || e.data !== data) begin
                errors++;
                $display("FAIL sb_access: got io=%0d we=%0d addr=%h data=%h expected io=%0d we=%0d addr=%h data=%h",
                         is_io, we, addr, data, e.is_io, e.we, e.addr, e.data);
            end
        end
    endfunction

    // Memory / IO responder with programmable wait states, plus irq source.
    initial begin
        int          mem_cnt, io_cnt;
        logic [15:0] ma0, ia0;
        logic [7:0]  md0, id0;
        mem_cnt = 0; io_cnt = 0; ma0 = '0; ia0 = '0; md0 = '0; id0 = '0;
        mem_ack = 1'b0; io_ack = 1'b0; mem_rdata = '0; io_rdata = '0; irq_pending = 1'b0;
        forever begin
            @(negedge clock);
            irq_pending = (irq_at != 0) && (upd_cnt >= irq_at - 1);
            if (flag_we) upd_cnt++;
            if (mem_req) begin
                if (mem_cnt == 0) begin ma0 = mem_addr; md0 = mem_wdata; end
                else if (mem_addr !== ma0 || (mem_we && mem_wdata !== md0)) stab_err++;
                if (mem_cnt == mem_wait) begin
                    mem_ack = 1'b1;
                    if (!mem_we) begin mem_rdata = 8'(cur_d0 + rd_cnt * cur_step); rd_cnt++; end
                    log_access(1'b0, mem_we, mem_addr, mem_we ? mem_wdata : 8'h00);
                    mem_cnt = 0;
                end else begin
                    mem_ack = 1'b0; mem_cnt++;
                end
            end else begin
                mem_ack = 1'b0; mem_cnt = 0;
            end
            if (io_req) begin
                if (io_cnt == 0) begin ia0 = io_addr; id0 = io_wdata; end
                else if (io_addr !== ia0 || (io_we && io_wdata !== id0)) stab_err++;
                if (io_cnt == io_wait) begin
                    io_ack = 1'b1;
                    if (!io_we) begin io_rdata = 8'(cur_d0 + rd_cnt * cur_step); rd_cnt++; end
                    log_access(1'b1, io_we, io_addr, io_we ? io_wdata : 8'h00);
                    io_cnt = 0;
                end else begin
                    io_ack = 1'b0; io_cnt++;
                end
            end else begin
                io_ack = 1'b0; io_cnt = 0;
            end
        end
    end

    task automatic setup(input vec_t v);
        logic [7:0]  bk, dk;
        logic [15:0] hk;
        sb.delete();
        mem_wait = v.mw; io_wait = v.iw; irq_at = v.irq_at;
        cur_d0 = v.d0; cur_step = v.step;
        rd_cnt = 0; upd_cnt = 0; stab_err = 0;
        for (int k = 0; k < v.e_iters; k++) begin
            bk = 8'(v.b - k);
            hk = v.op_dec ? 16'(v.hl - k) : 16'(v.hl + k);
            dk = 8'(v.d0 + k * v.step);
            if (v.op_in) begin
                sb.push_back('{1'b1, 1'b0, {bk, v.c}, 8'h00});
                sb.push_back('{1'b0, 1'b1, hk, dk});
            end else begin
                sb.push_back('{1'b0, 1'b0, hk, 8'h00});
                sb.push_back('{1'b1, 1'b1, {8'(bk - 8'd1), v.c}, dk});
            end
        end
    endtask

    task automatic pulse_start(input vec_t v);
        @(negedge clock);
        op_in = v.op_in; op_dec = v.op_dec; op_rep = v.op_rep;
        hl_in = v.hl; b_in = v.b; c_in = v.c;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, exp_x;
        logic [4:0] lastx;
        setup(v);
        pulse_start(v);
        cyc = 1; lastx = '0;
        while (!done && cyc < 3000) begin
            if (flag_we) lastx = xpt;
            @(negedge clock);
            cyc++;
        end
        if (!done) begin
            chk({v.name, "_timeout"}, 32'(done), 32'd1);
        end else begin
`ifdef BLOCK_IO_SEQUENCER_XPT_EN
            exp_x = v.e_xpt;
`else
            exp_x = 0;
`endif
            chk({v.name, "_cycles"}, 32'(cyc), 32'(v.e_cyc));
            chk({v.name, "_hl"}, 32'(hl_out), 32'(v.e_hl));
            chk({v.name, "_b"}, 32'(b_out), 32'(v.e_b));
            chk({v.name, "_z"}, 32'(flag_z), 32'(v.e_z));
            chk({v.name, "_n"}, 32'(flag_n), 32'(v.e_n));
            chk({v.name, "_rewind"}, 32'(rewind), 32'(v.e_rw));
            chk({v.name, "_iters"}, 32'(upd_cnt), 32'(v.e_iters));
            chk({v.name, "_xpt"}, 32'(lastx), 32'(exp_x));
            chk({v.name, "_sb_left"}, 32'(sb.size()), 32'd0);
            chk({v.name, "_stable"}, 32'(stab_err), 32'd0);
            @(negedge clock);
            chk({v.name, "_done_pulse"}, 32'({done, rewind, busy}), 32'd0);
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{"OUTI",        1'b0,1'b0,1'b0, 16'h4000, 8'h03, 8'h10, 8'h85, 8'h00, 0,0,0, 16'h4001, 8'h02, 1'b0,1'b1,1'b0, 1,   4,   2};
        vecs[1] = '{"INDR",        1'b1,1'b1,1'b1, 16'h8000, 8'h02, 8'h20, 8'h11, 8'h11, 0,0,0, 16'h7FFE, 8'h00, 1'b1,1'b0,1'b0, 2,   7,   2};
        vecs[2] = '{"OTIR_irq",    1'b0,1'b0,1'b1, 16'h2000, 8'h05, 8'h30, 8'h90, 8'h01, 2,0,0, 16'h2002, 8'h03, 1'b0,1'b1,1'b1, 2,   7,   2};
        vecs[3] = '{"INI_memwait", 1'b1,1'b0,1'b0, 16'h1234, 8'h01, 8'h55, 8'h7F, 8'h00, 0,3,0, 16'h1235, 8'h00, 1'b1,1'b0,1'b0, 1,   7,   5};
        vecs[4] = '{"OTDR_b0",     1'b0,1'b1,1'b1, 16'h0100, 8'h00, 8'h99, 8'h00, 8'h01, 0,0,0, 16'h0000, 8'h00, 1'b1,1'b1,1'b0, 256, 769, 2};
        vecs[5] = '{"OUTD_wrap",   1'b0,1'b1,1'b0, 16'h0000, 8'h01, 8'h00, 8'h40, 8'h00, 0,0,0, 16'hFFFF, 8'h00, 1'b1,1'b0,1'b0, 1,   4,   2};
        vecs[6] = '{"INI_iowait",  1'b1,1'b0,1'b0, 16'hFFFF, 8'h80, 8'h01, 8'hC3, 8'h00, 0,1,2, 16'h0000, 8'h7F, 1'b0,1'b1,1'b0, 1,   7,   5};

        start = 1'b0; op_in = 1'b0; op_dec = 1'b0; op_rep = 1'b0;
        hl_in = '0; b_in = '0; c_in = '0;
        notReset = 1'b1;
        #1 notReset = 1'b0;
        #20;
        chk("rst_ctrl", 32'({mem_req, mem_we, io_req, io_we, busy, done, rewind, flag_we, flag_z, flag_n}), 32'd0);
        chk("rst_hl", 32'(hl_out), 32'd0);
        chk("rst_b", 32'(b_out), 32'd0);
        chk("rst_xpt", 32'(xpt), 32'd0);
        @(negedge clock);
        notReset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset hitting INIR while the memory write is waiting for ack.
        setup('{"INIR_rst", 1'b1,1'b0,1'b1, 16'h1000, 8'h03, 8'h40, 8'h5A, 8'h00, 0,2,0,
                16'h0000, 8'h00, 1'b0,1'b0,1'b0, 3, 0, 0});
        pulse_start('{"INIR_rst", 1'b1,1'b0,1'b1, 16'h1000, 8'h03, 8'h40, 8'h5A, 8'h00, 0,2,0,
                      16'h0000, 8'h00, 1'b0,1'b0,1'b0, 3, 0, 0});
        n = 0;
        while (!mem_req && n < 50) begin @(negedge clock); n++; end
        chk("rst_mid_reached_dst", 32'(mem_req), 32'd1);
        chk("rst_mid_dst_addr", 32'(mem_addr), 32'h1000);
        #2 notReset = 1'b0;
        #1;
        chk("rst_mid_req", 32'({mem_req, mem_we, io_req, busy}), 32'd0);
        chk("rst_mid_regs", 32'({hl_out, b_out}), 32'd0);
        @(negedge clock);
        @(negedge clock);
        sb.delete();
        notReset = 1'b1;
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
